shift_arbiter: RTL and testbench
================================

# shift_arbiter

Sequencing and arbitration controller for the shared bi-directional shifter in the Mosaic functional unit. Two requesters (A and B) submit shift operations over a valid/ready handshake. The block grants them round-robin, drives the shifter's operand, control and latch-enable inputs, waits a fixed latency and returns the result to the owning requester over a second valid/ready handshake. Only one operation is in flight at a time.

## Interface
Parameters:
- LAT, default 1: cycles between the SH_EN pulse and the capture of SH_Z. Legal range 1..7.

Ports:
- CLK  in  1  the single clock; all state changes on its rising edge
- RST_N  in  1  reset, asynchronous and active-low
- A_VALID  in  1  requester A has an operation
- A_READY  out  1  requester A's operation is accepted this cycle
- A_X  in  32  operand for A
- A_S  in  5  shift amount for A
- A_LEFT  in  1  A requests a left shift
- A_LOG  in  1  A requests a logical right shift (0 = arithmetic)
- B_VALID, B_READY, B_X, B_S, B_LEFT, B_LOG  same as A, for requester B
- A_RVALID  out  1  result for A is valid on R_DATA
- A_RREADY  in  1  A accepts the result
- B_RVALID  out  1  result for B is valid on R_DATA
- B_RREADY  in  1  B accepts the result
- R_DATA  out  32  shared result bus
- SH_EN  out  1  shifter input-latch enable
- SH_X  out  32  shifter operand
- SH_S  out  5  shifter amount
- SH_LEFT  out  1  shifter direction
- SH_LOG  out  1  shifter logical/arithmetic select
- SH_Z  in  32  shifter result
- BUSY  out  1  the state is not IDLE

## Operation
- States:
  - IDLE → ISSUE on a handshake.
  - ISSUE → WAIT always.
  - WAIT → RESP when the counter expires.
  - RESP → IDLE when the owner's RREADY is high.
- In IDLE, one requester is granted. If only one VALID is high, that requester is granted. If both are high, the requester other than LAST (the last-granted requester) is granted.
  - The granted requester's READY is high combinationally in IDLE. The other READY is low.
  - Both READYs are low in every other state.
- Handshake is VALID&READY. On it, the following are registered:
  - OWNER = the granted requester
  - LAST = the granted requester
  - SH_X, SH_S, SH_LEFT, SH_LOG = the granted requester's operand fields
- ISSUE: SH_EN=1 for exactly this cycle; the counter is loaded with LAT.
- WAIT: the counter decrements each cycle. On its final cycle, R_DATA is loaded from SH_Z.
- RESP: OWNER's RVALID=1. R_DATA, and OWNER's RVALID while RREADY is low, stay stable.
- SH_X, SH_S, SH_LEFT and SH_LOG hold their last values until the next handshake. They are not cleared.
- The block performs no arithmetic on the operands. A left shift by 0 returns X unchanged because of the shifter's own behaviour.
- RREADY is ignored outside RESP. VALID is ignored outside IDLE. Operands are sampled only on the handshake edge.
- Reset values: state=IDLE, LAST=B (so A wins the first tie), all outputs 0.
- Reset asserted in any state aborts the operation: no response, RVALID drops immediately, and the in-flight result is lost.

## Timing
- Handshake in cycle t:
  - SH_EN=1 in cycle t+1.
  - WAIT occupies cycles t+2..t+1+LAT.
  - RVALID=1 from cycle t+2+LAT.
- With RREADY high at t+2+LAT, the state is IDLE at t+3+LAT and the next handshake can occur in that cycle.
- Peak throughput is one operation per LAT+3 cycles.
- SH_* fields are stable from cycle t+1 through the SH_Z capture edge.
- READY is a combinational function of state, VALIDs and LAST. There is no path from SH_Z to any handshake signal.

## Test plan
1. Single A request, LAT=1: X=0x80000001, S=4, LEFT=0, LOG=0 → SH_EN pulses one cycle, A_RVALID at t+3, R_DATA=0xF8000000, B_RVALID stays 0.
2. After reset, A and B valid in the same cycle; B has X=0x0000000F, S=8, LEFT=1 → A is granted first, then B; B_RVALID with R_DATA=0x00000F00.
3. A and B valid continuously, RREADYs tied high, 6 operations → grants alternate A, B, A, B, A, B; handshakes spaced LAT+3 cycles apart.
4. A result with A_RREADY held low for 5 cycles → A_RVALID and R_DATA stable, no READY asserted, BUSY=1; A_RREADY high → IDLE on the next cycle.
5. RST_N asserted during WAIT → all outputs 0 immediately, no RVALID ever appears for that operation; with both valid after release, A is granted first.
6. Left shift by zero: X=0x12345678, S=0, LEFT=1 → R_DATA=0x12345678.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter and sequencer for the shared shifter: grants A or B, issues one operation,
// waits LAT cycles, then returns the captured result to the owning requester.
module shift_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [31:0] a_x,
    input  logic [4:0]  a_s,
    input  logic        a_left,
    input  logic        a_log,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [31:0] b_x,
    input  logic [4:0]  b_s,
    input  logic        b_left,
    input  logic        b_log,
    output logic        a_rvalid,
    input  logic        a_rready,
    output logic        b_rvalid,
    input  logic        b_rready,
    output logic [31:0] r_data,
    output logic        sh_en,
    output logic [31:0] sh_x,
    output logic [4:0]  sh_s,
    output logic        sh_left,
    output logic        sh_log,
    input  logic [31:0] sh_z,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e     state_q;
    logic       owner_q;  // 0 = A, 1 = B
    logic       last_q;   // 0 = A, 1 = B
    logic [2:0] cnt_q;
    logic       idle;
    logic       gnt_a;
    logic       gnt_b;

    assign idle = (state_q == StIdle);

    // On a tie the requester that was not granted last wins; gated by reset so every
    // output reads 0 while reset is held.
    assign gnt_a = rst_n & idle & a_valid & (~b_valid | last_q);
    assign gnt_b = rst_n & idle & b_valid & (~a_valid | ~last_q);

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;
    assign busy    = ~idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= 3'd0;
            sh_en    <= 1'b0;
            sh_x     <= 32'd0;
            sh_s     <= 5'd0;
            sh_left  <= 1'b0;
            sh_log   <= 1'b0;
            r_data   <= 32'd0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            sh_en <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (gnt_a || gnt_b) begin
                        state_q <= StIssue;
                        owner_q <= gnt_b;
                        last_q  <= gnt_b;
                        sh_en   <= 1'b1;
                        sh_x    <= gnt_b ? b_x    : a_x;
                        sh_s    <= gnt_b ? b_s    : a_s;
                        sh_left <= gnt_b ? b_left : a_left;
                        sh_log  <= gnt_b ? b_log  : a_log;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                    cnt_q   <= 3'(LAT);
                end
                StWait: begin
                    cnt_q <= cnt_q - 3'd1;
                    // Final wait cycle: the shifter result is valid now.
                    if (cnt_q == 3'd1) begin
                        state_q  <= StResp;
                        r_data   <= sh_z;
                        a_rvalid <= ~owner_q;
                        b_rvalid <= owner_q;
                    end
                end
                StResp: begin
                    if (owner_q ? b_rready : a_rready) begin
                        state_q  <= StIdle;
                        a_rvalid <= 1'b0;
                        b_rvalid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized self-checking bench for shift_arbiter with a latency-accurate shifter model.
module tb_shift_arbiter;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 0, b_valid = 0, a_left = 0, a_log = 0, b_left = 0, b_log = 0;
    logic        a_rready = 0, b_rready = 0;
    logic [31:0] a_x = 0, b_x = 0;
    logic [4:0]  a_s = 0, b_s = 0;
    logic        a_ready, b_ready, a_rvalid, b_rvalid, sh_en, sh_left, sh_log, busy;
    logic [31:0] r_data, sh_x, sh_z;
    logic [4:0]  sh_s;

    int n_checks = 0;
    int n_errors = 0;
    logic m_last = 1'b1;  // reference model: last granted, 1 = B

    // Shifter model: latches on sh_en, result is garbage until LAT cycles have elapsed.
    logic [31:0] lat_x = 0;
    logic [4:0]  lat_s = 0;
    logic        lat_l = 0, lat_g = 0;
    int          age = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_s(a_s), .a_left(a_left),
        .a_log(a_log),
        .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_s(b_s), .b_left(b_left),
        .b_log(b_log),
        .a_rvalid(a_rvalid), .a_rready(a_rready), .b_rvalid(b_rvalid), .b_rready(b_rready),
        .r_data(r_data), .sh_en(sh_en), .sh_x(sh_x), .sh_s(sh_s), .sh_left(sh_left),
        .sh_log(sh_log), .sh_z(sh_z), .busy(busy)
    );

    function automatic logic [31:0] ref_shift(logic [31:0] x, logic [4:0] s, logic l, logic g);
        if (l) return x << s;
        if (g) return x >> s;
        return 32'($signed(x) >>> s);
    endfunction

    always @(posedge clk) begin
        if (sh_en) begin
            lat_x <= sh_x; lat_s <= sh_s; lat_l <= sh_left; lat_g <= sh_log;
            age <= 1;
        end else if (age > 0 && age < 100) begin
            age <= age + 1;
        end
    end

    assign sh_z = (age >= int'(LAT)) ? ref_shift(lat_x, lat_s, lat_l, lat_g) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge with the DUT expected idle; returns just after the
    // edge that leaves the response state.
    task automatic do_op(input logic av, input logic bv,
                         input logic [31:0] ax, input logic [4:0] as_, input logic al,
                         input logic ag,
                         input logic [31:0] bx, input logic [4:0] bs, input logic bl,
                         input logic bg, input int hold);
        logic gb;
        logic [31:0] ox, ex;
        logic [4:0]  os;
        logic        ol, og;
        a_valid = av; b_valid = bv;
        a_x = ax; a_s = as_; a_left = al; a_log = ag;
        b_x = bx; b_s = bs; b_left = bl; b_log = bg;
        a_rready = 0; b_rready = 0;
        gb = (av && bv) ? !m_last : bv;
        ox = gb ? bx : ax; os = gb ? bs : as_; ol = gb ? bl : al; og = gb ? bg : ag;
        ex = ref_shift(ox, os, ol, og);
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
        check("a_ready", {31'd0, a_ready}, {31'd0, !gb});
        check("b_ready", {31'd0, b_ready}, {31'd0, gb});
        m_last = gb;
        step();
        // Inputs are ignored once the operation is accepted.
        a_valid = 1'($urandom); b_valid = 1'($urandom);
        a_x = $urandom; b_x = $urandom; a_s = 5'($urandom); b_s = 5'($urandom);
        @(negedge clk);
        check("issue_en", {31'd0, sh_en}, 1);
        check("issue_x", sh_x, ox);
        check("issue_ctl", {25'd0, sh_s, sh_left, sh_log}, {25'd0, os, ol, og});
        check("issue_ready", {30'd0, a_ready, b_ready}, 0);
        check("issue_busy", {31'd0, busy}, 1);
        for (int i = 0; i < int'(LAT); i++) begin
            step();
            a_rready = 1'($urandom); b_rready = 1'($urandom);
            @(negedge clk);
            check("wait_en", {31'd0, sh_en}, 0);
            check("wait_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
            check("wait_ready", {30'd0, a_ready, b_ready}, 0);
            check("wait_x", sh_x, ox);
        end
        for (int i = 0; i <= hold; i++) begin
            step();
            if (gb) begin b_rready = (i == hold); a_rready = 1'($urandom); end
            else    begin a_rready = (i == hold); b_rready = 1'($urandom); end
            @(negedge clk);
            check("resp_rvalid", {30'd0, a_rvalid, b_rvalid}, {30'd0, !gb, gb});
            check("resp_data", r_data, ex);
            check("resp_ready", {30'd0, a_ready, b_ready}, 0);
            check("resp_busy", {31'd0, busy}, 1);
        end
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {a_ready, b_ready, a_rvalid, b_rvalid, sh_en, sh_left, sh_log, busy,
                    3'd0, sh_s}, 0);
        check({tag, "_data"}, r_data | sh_x, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        a_valid = 1; b_valid = 1;
        #12;
        check_all_zero("reset");
        a_valid = 0; b_valid = 0;
        step();
        rst_n = 1;
        step();
        // Tie after reset: A then B.
        do_op(1, 1, 32'h0000_1111, 5'd1, 1, 0, 32'h0000_000F, 5'd8, 1, 0, 0);
        do_op(1, 1, 32'h0000_1111, 5'd1, 1, 0, 32'h0000_000F, 5'd8, 1, 0, 0);
        // Single A arithmetic right shift.
        do_op(1, 0, 32'h8000_0001, 5'd4, 0, 0, 32'h0, 5'd0, 0, 0, 0);
        // Left shift by zero.
        do_op(1, 0, 32'h1234_5678, 5'd0, 1, 0, 32'h0, 5'd0, 0, 0, 0);
        // Owner back-pressure.
        do_op(1, 0, 32'hF0F0_0000, 5'd3, 0, 1, 32'h0, 5'd0, 0, 0, 5);
        // Continuous contention: must alternate.
        for (int i = 0; i < 6; i++)
            do_op(1, 1, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 0);
        for (int i = 0; i < 40; i++) begin
            int pat;
            pat = $urandom_range(0, 2);
            do_op(pat != 1, pat != 0, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, 5'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
        end
        // Reset during WAIT aborts the operation.
        a_valid = 1; b_valid = 1; a_x = 32'hAAAA_5555; a_s = 5'd2; b_x = 32'h1; b_s = 5'd1;
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        check_all_zero("abort");
        a_valid = 0; b_valid = 0;
        m_last = 1'b1;
        step();
        rst_n = 1;
        for (int i = 0; i < int'(LAT) + 4; i++) begin
            @(negedge clk);
            check("abort_quiet", {29'd0, a_rvalid, b_rvalid, busy}, 0);
            step();
        end
        do_op(1, 1, 32'h0000_00F0, 5'd4, 0, 1, 32'h0000_0001, 5'd1, 1, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
